// File: rtl/mem_stage_sram_ctrl_if.sv
// Interface between the MEM stage, the SRAM controller and the external 16-bit SRAM.
// The master side is the pipeline plus the SRAM pins. The slave side is the controller.
interface mem_stage_sram_ctrl_if #(
    parameter int unsigned SRAM_AW = 18
);
    logic               mem_read;
    logic               mem_write;
    logic [31:0]        addr;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic               sram_dq_oe;
    logic [15:0]        sram_dq_in;
    logic               sram_we_n;
    logic               sram_oe_n;

    modport master (
        output mem_read, mem_write, addr, wdata, sram_dq_in,
        input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata, sram_dq_in,
        output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
    );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller. Each 32-bit word access is split into two
// half-word phases on a 16-bit asynchronous SRAM, and the pipeline is stalled until the access completes.
module mem_stage_sram_ctrl #(
    parameter int unsigned BASE_ADDR    = 1024,
    parameter int unsigned PHASE_CYCLES = 2,
    parameter int unsigned SRAM_AW      = 18
) (
    input  logic                    clk,
    input  logic                    rst,
    mem_stage_sram_ctrl_if.slave    bus
);
    localparam int unsigned CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic [SRAM_AW-2:0] widx_q;
    logic [31:0]        wdata_q;
    logic               write_q;
    logic [31:0]        rdata_q;
    logic [31:0]        off;
    logic               req;
    logic               phase_end;
    logic               capture_lo;
    logic               capture_hi;
    logic               unused_off_bits;

    assign req             = bus.mem_read | bus.mem_write;
    assign off             = bus.addr - 32'(BASE_ADDR);
    assign unused_off_bits = ^{off[31:SRAM_AW+1], off[1:0]};
    assign phase_end       = (cnt == LAST);
    assign bus.rdata       = rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            widx_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                cnt <= '0;
                if (req) begin
                    widx_q  <= off[SRAM_AW:2];
                    wdata_q <= bus.wdata;
                    // A simultaneous read and write request is performed as a write.
                    write_q <= bus.mem_write;
                end
            end else if (phase_end || state == DONE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (capture_lo) rdata_q[15:0]  <= bus.sram_dq_in;
            if (capture_hi) rdata_q[31:16] <= bus.sram_dq_in;
        end
    end

    // The strobes are decoded from state alone, so an asynchronous reset releases them immediately.
    always_comb begin
        state_next      = state;
        bus.ready       = 1'b0;
        bus.sram_addr   = '0;
        bus.sram_dq_out = '0;
        bus.sram_dq_oe  = 1'b0;
        bus.sram_we_n   = 1'b1;
        bus.sram_oe_n   = 1'b1;
        capture_lo      = 1'b0;
        capture_hi      = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = ~req;
                if (req) state_next = LO;
            end
            LO: begin
                bus.sram_addr = {widx_q, 1'b0};
                if (write_q) begin
                    bus.sram_dq_oe  = 1'b1;
                    bus.sram_we_n   = 1'b0;
                    bus.sram_dq_out = wdata_q[15:0];
                end else begin
                    bus.sram_oe_n = 1'b0;
                    capture_lo    = phase_end;
                end
                if (phase_end) state_next = HI;
            end
            HI: begin
                bus.sram_addr = {widx_q, 1'b1};
                if (write_q) begin
                    bus.sram_dq_oe  = 1'b1;
                    bus.sram_we_n   = 1'b0;
                    bus.sram_dq_out = wdata_q[31:16];
                end else begin
                    bus.sram_oe_n = 1'b0;
                    capture_hi    = phase_end;
                end
                if (phase_end) state_next = DONE;
            end
            DONE: begin
                bus.ready  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule
